// File: rtl/cps_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scanner.
`timescale 1ns/1ps
package cps_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    typedef logic [1:0] digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t       SEG_OFF   = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

endpackage

// File: rtl/cps_scan_timer.sv
// Slot/digit sequencer: each digit slot is BLANK_CYCLES dark followed by the lit part.
// Exposes next-cycle state so the top can register its outputs aligned to the scan.
`timescale 1ns/1ps
module cps_scan_timer
    import cps_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic   clk,
    input  logic   rst_n,
    output state_t state_next,
    output digit_t digit_next,
    output logic   frame_next,
    output logic   frame_start
);

    localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    state_t          state_q, state_d;
    digit_t          digit_q, digit_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            first_q;
    logic            frame_start_q;

    // The first edge after reset is itself a frame boundary, so the counters hold there.
    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        cnt_d      = cnt_q;
        frame_next = 1'b0;
        if (first_q) begin
            frame_next = 1'b1;
        end else begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            case (state_q)
                BLANK: if (cnt_q == BLANK_LAST) state_d = SHOW;
                SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d    = BLANK;
                        digit_d    = digit_q + 1'b1;
                        frame_next = (digit_q == 2'd3);
                    end
                end
                default: state_d = BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BLANK;
            digit_q       <= '0;
            cnt_q         <= '0;
            first_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            digit_q       <= digit_d;
            cnt_q         <= cnt_d;
            first_q       <= 1'b0;
            frame_start_q <= frame_next;
        end
    end

    assign state_next  = state_d;
    assign digit_next  = digit_d;
    assign frame_start = frame_start_q;

endmodule

// File: rtl/cps_display_scanner.sv
// Common-anode 4-digit display driver: per-frame snapshot of the digit patterns,
// blanked digit scanning and whole-display blinking while redLed is set.
`timescale 1ns/1ps
module cps_display_scanner
    import cps_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [6:0] display1,
    input  logic [6:0] display2,
    input  logic [6:0] display3,
    input  logic [6:0] display4,
    input  logic       redLed,
    input  logic       greenLed,
    output logic [3:0] anode,
    output logic [6:0] segment,
    output logic       ledGreen,
    output logic       frameStart
);

    localparam int BW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    state_t     state_next;
    digit_t     digit_next;
    logic       frame_next;

    seg_t [3:0]    snap_q, snap_d;
    logic          phase_on_q, phase_on_d;
    logic          frame_on_q, frame_on_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [3:0]    anode_q, anode_d;
    seg_t          segment_q, segment_d;
    logic          led_green_q;

    cps_scan_timer #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk         (Clk),
        .rst_n       (Rst),
        .state_next  (state_next),
        .digit_next  (digit_next),
        .frame_next  (frame_next),
        .frame_start (frameStart)
    );

    // frame_on latches the phase in force when the frame begins; phase_on is the
    // phase the following red frame will use, so a full BLINK_FRAMES run is shown.
    always_comb begin
        snap_d      = snap_q;
        phase_on_d  = phase_on_q;
        frame_on_d  = frame_on_q;
        blink_cnt_d = blink_cnt_q;
        if (frame_next) begin
            snap_d = {display4, display3, display2, display1};
            if (!redLed) begin
                blink_cnt_d = '0;
                phase_on_d  = 1'b1;
                frame_on_d  = 1'b1;
            end else begin
                frame_on_d = phase_on_q;
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    phase_on_d  = ~phase_on_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
        end

        anode_d   = ANODE_OFF;
        segment_d = SEG_OFF;
        if (state_next == SHOW) begin
            anode_d[digit_next] = 1'b0;
            if (frame_on_q) segment_d = ~snap_q[digit_next];
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            snap_q      <= '0;
            phase_on_q  <= 1'b1;
            frame_on_q  <= 1'b1;
            blink_cnt_q <= '0;
            anode_q     <= ANODE_OFF;
            segment_q   <= SEG_OFF;
            led_green_q <= 1'b0;
        end else begin
            snap_q      <= snap_d;
            phase_on_q  <= phase_on_d;
            frame_on_q  <= frame_on_d;
            blink_cnt_q <= blink_cnt_d;
            anode_q     <= anode_d;
            segment_q   <= segment_d;
            led_green_q <= greenLed;
        end
    end

    assign anode    = anode_q;
    assign segment  = segment_q;
    assign ledGreen = led_green_q;

endmodule

// File: tb/tb_cps_display_scanner.sv
// Self-checking bench for cps_display_scanner: frame-position reference model,
// pattern table, blink/reset corner sequences and randomized input traffic.
`timescale 1ns/1ps
module tb_cps_display_scanner;

    localparam int DC    = 8;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * DC;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [6:0] display1 = '0, display2 = '0, display3 = '0, display4 = '0;
    logic       redLed = 1'b0, greenLed = 1'b0;
    logic [3:0] anode;
    logic [6:0] segment;
    logic       ledGreen, frameStart;

    always #5 Clk = ~Clk;

    cps_display_scanner #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .display1   (display1),
        .display2   (display2),
        .display3   (display3),
        .display4   (display4),
        .redLed     (redLed),
        .greenLed   (greenLed),
        .anode      (anode),
        .segment    (segment),
        .ledGreen   (ledGreen),
        .frameStart (frameStart)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: cycle index within the run since reset release.
    int         c;
    logic [6:0] m_snap [4];
    bit         m_on;
    int         m_k;
    logic       m_green;

    typedef struct packed {
        logic [3:0][6:0] d;
        logic [3:0][6:0] e;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s cycle=%0d got=%0h want=%0h", name, c, act, exp);
        end
    endtask

    task automatic model_reset();
        c    = -1;
        m_k  = 0;
        m_on = 1'b1;
        for (int i = 0; i < 4; i++) m_snap[i] = '0;
    endtask

    task automatic model_edge();
        c++;
        m_green = greenLed;
        if (c % FRAME == 0) begin
            m_snap[0] = display1;
            m_snap[1] = display2;
            m_snap[2] = display3;
            m_snap[3] = display4;
            if (redLed) begin
                m_on = ((m_k / BF) % 2 == 0);
                m_k++;
            end else begin
                m_k  = 0;
                m_on = 1'b1;
            end
        end
    endtask

    task automatic step();
        int         pos, dg;
        bit         lit;
        logic [3:0] ea;
        logic [6:0] es;
        @(posedge Clk);
        model_edge();
        #1;
        pos = c % FRAME;
        dg  = pos / DC;
        lit = (pos % DC) >= BC;
        ea  = 4'hF;
        es  = 7'h7F;
        if (lit) begin
            ea[dg] = 1'b0;
            if (m_on) es = ~m_snap[dg];
        end
        check("anode", anode, ea);
        check("segment", segment, es);
        check("frameStart", frameStart, pos == 0);
        check("ledGreen", ledGreen, m_green);
    endtask

    always @(negedge Clk)
        assert ($countones(anode) >= 3)
        else $error("FAIL anode_exclusive got=%h want=at most one low bit", anode);

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", c);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [6:0] r7, be;
        int         pos;

        tbl[0].d = {7'h4F, 7'h5B, 7'h06, 7'h3F}; tbl[0].e = {7'h30, 7'h24, 7'h79, 7'h40};
        tbl[1].d = {7'h40, 7'h01, 7'h7F, 7'h00}; tbl[1].e = {7'h3F, 7'h7E, 7'h00, 7'h7F};
        tbl[2].d = {7'h7F, 7'h07, 7'h7D, 7'h6D}; tbl[2].e = {7'h00, 7'h78, 7'h02, 7'h12};
        tbl[3].d = {7'h5E, 7'h39, 7'h7C, 7'h77}; tbl[3].e = {7'h21, 7'h46, 7'h03, 7'h08};

        model_reset();
        display1 = 7'h3F; display2 = 7'h06; display3 = 7'h5B; display4 = 7'h4F;
        greenLed = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_anode", anode, 4'hF);
        check("rst_segment", segment, 7'h7F);
        check("rst_frameStart", frameStart, 1'b0);
        check("rst_ledGreen", ledGreen, 1'b0);

        // Scan order, pattern mapping and mid-frame coherency.
        Rst = 1'b1;
        model_reset();
        for (int i = 0; i < 48; i++) begin
            step();
            if (c == 0)  check("first_frameStart", frameStart, 1'b1);
            if (c == 2)  check("dig0_anode", anode, 4'hE);
            if (c == 7)  check("dig0_seg_old", segment, 7'h40);
            if (c == 18) check("dig2_anode", anode, 4'hB);
            if (c == 26) check("dig3_seg", segment, 7'h30);
            if (c == 32) check("second_frameStart", frameStart, 1'b1);
            if (c == 34) check("dig0_seg_new", segment, 7'h79);
            if (c == 12) display1 = 7'h06;
            greenLed = i[0];
        end

        // Pattern table, one frame per record.
        for (int v = 0; v < 4; v++) begin
            while (c % FRAME != FRAME - 1) step();
            display1 = tbl[v].d[0]; display2 = tbl[v].d[1];
            display3 = tbl[v].d[2]; display4 = tbl[v].d[3];
            for (int j = 0; j < FRAME; j++) begin
                step();
                pos = c % FRAME;
                if ((pos % DC) >= BC)
                    check($sformatf("vec%0d_dig%0d", v, pos / DC), segment, tbl[v].e[pos / DC]);
            end
        end

        // Blink: on 2 frames, off 2 frames, then drop redLed in the off phase.
        while (c % FRAME != FRAME - 1) step();
        redLed = 1'b1;
        for (int f = 0; f < 5; f++) begin
            for (int j = 0; j < FRAME; j++) begin
                step();
                pos = c % FRAME;
                if (pos == DC + BC) begin
                    be = (f < 2 || f == 4) ? tbl[3].e[1] : 7'h7F;
                    check($sformatf("blink_f%0d_seg", f), segment, be);
                    check($sformatf("blink_f%0d_anode", f), anode, 4'hD);
                end
                if (f == 3 && pos == 10) redLed = 1'b0;
            end
        end

        // Asynchronous reset in the middle of a lit slot.
        while (c % FRAME != 20) step();
        Rst = 1'b0;
        #1;
        check("async_anode", anode, 4'hF);
        check("async_segment", segment, 7'h7F);
        check("async_ledGreen", ledGreen, 1'b0);
        display1 = 7'h7F;
        repeat (2) @(posedge Clk);
        #1;
        check("async_hold_anode", anode, 4'hF);
        Rst = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            step();
            if (c == 0) check("restart_frameStart", frameStart, 1'b1);
            if (c == 2) check("restart_dig0_seg", segment, 7'h00);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            step();
            greenLed = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                r7 = 7'($urandom);
                case ($urandom_range(0, 3))
                    0: display1 = r7;
                    1: display2 = r7;
                    2: display3 = r7;
                    default: display4 = r7;
                endcase
            end
            if ($urandom_range(0, 49) == 0) redLed = ~redLed;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
